condicionador_botao_acao: RTL and testbench
===========================================

# condicionador_botao_acao

Conditions the raw push-button used to step the RPN operand/result sequencer: synchronises the asynchronous pad input, debounces it, and emits exactly one single-cycle `action_pulso` per confirmed press. It sits directly upstream of the sequencer logic and its state register. `action_pulso` feeds the sequencer's action input and is used to produce the register enables.

## Interface
- `CICLOS_DEBOUNCE`, default 500000: consecutive stable synchronised samples required to accept a level change (10 ms at 50 MHz); legal range ≥ 2.
- `ATIVO_BAIXO`, default 1: 1 = pad reads 0 when pressed (DE-board KEY); 0 = pad reads 1 when pressed.

- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `botao_bruto`  in  1  raw button pad level, asynchronous to `clk`.
- `action_pulso`  out  1  one-cycle, active-high pulse per accepted press.
- `botao_estavel`  out  1  debounced pressed level (1 = pressed).

## Operation
- Synchroniser: two flops in series on `botao_bruto`. The result is normalised by `ATIVO_BAIXO` to `s` (1 = pressed). Flop reset values correspond to "released": `s` = 0 after reset.
- FSM states:
  - SOLTO: stable released.
  - CONFIRMA_PRESS: candidate press being confirmed.
  - PRESSIONADO: stable pressed.
  - CONFIRMA_SOLTURA: candidate release being confirmed.
- Counter `cnt` has width $clog2(CICLOS_DEBOUNCE).
- SOLTO:
  - `s`=1 → CONFIRMA_PRESS, `cnt`←1.
  - Otherwise stay.
- CONFIRMA_PRESS:
  - `s`=0 → SOLTO, `cnt`←0 (bounce discarded, no pulse).
  - `cnt`==CICLOS_DEBOUNCE−1 and `s`=1 → PRESSIONADO, `cnt`←0, `action_pulso`←1.
  - Otherwise `cnt`←`cnt`+1.
- PRESSIONADO:
  - `s`=0 → CONFIRMA_SOLTURA, `cnt`←1.
  - Otherwise stay; the pulse is never repeated while held.
- CONFIRMA_SOLTURA: mirror of CONFIRMA_PRESS.
  - `s`=1 → PRESSIONADO, `cnt`←0 (no new pulse).
  - Full count of `s`=0 → SOLTO, `cnt`←0.
- Outputs:
  - `action_pulso` is registered and high only in the first cycle of PRESSIONADO entered from CONFIRMA_PRESS.
  - `botao_estavel` is registered: 1 in PRESSIONADO and CONFIRMA_SOLTURA, 0 otherwise.
- Release never generates a pulse. The counter never wraps; it is only compared and cleared.

## Timing
- Reset values: state SOLTO, `cnt`=0, both sync flops at released level, `action_pulso`=0, `botao_estavel`=0.
- `rst_n` assertion mid-confirmation or mid-pulse clears everything immediately (asynchronous). A button held through reset release must be re-confirmed, taking a full CICLOS_DEBOUNCE count, and then does generate a pulse.
- Latency: define edge k as the first clock edge sampling the pressed pad level. If the level is held, `action_pulso` is high in the cycle following edge k+CICLOS_DEBOUNCE+1, i.e. CICLOS_DEBOUNCE+2 edges.
  - `botao_estavel` rises at the same edge.
  - Release latency is identical for the fall of `botao_estavel`.
- Pulse width is exactly 1 `clk` cycle. The minimum spacing between two pulses is 2·CICLOS_DEBOUNCE cycles, because press and release must each be confirmed.
- Any single-cycle glitch of `s` shorter than CICLOS_DEBOUNCE restarts confirmation; the stable state is unchanged.

## Structure
- Shared include `defs_sequenciador.vh` holds:
  - 2-bit state codes: SOLTO=2'b00, CONFIRMA_PRESS=2'b01, PRESSIONADO=2'b10, CONFIRMA_SOLTURA=2'b11.
  - The sequencer's state codes, so both FSMs are decoded consistently in debug.
- One sub-module: `sincronizador_2ff`, a generic 1-bit two-flop synchroniser with async active-low reset and a reset-value parameter. It is reused later for switch inputs.
- FSM, counter and output registers stay in the top module.

## Test plan
All scenarios use CICLOS_DEBOUNCE=4 and ATIVO_BAIXO=1.
1. Reset: hold `rst_n`=0 with `botao_bruto`=0 (pressed) → `action_pulso`=0, `botao_estavel`=0 throughout. Release reset → single pulse exactly 6 edges later.
2. Clean press: drive `botao_bruto` 1→0 and hold for 20 cycles → one pulse at edge k+6, width 1; `botao_estavel`=1 from the same cycle. Release → `botao_estavel` falls 6 edges after the release, with no pulse.
3. Bounce: toggle `botao_bruto` 0/1 every 2 cycles for 16 cycles, then hold 0 → no pulse during bouncing; exactly one pulse 6 edges after the final stable 0.
4. Release glitch: while PRESSIONADO, drive 1 for 2 cycles then 0 → `botao_estavel` stays 1 and no second pulse.
5. Reset mid-confirmation: assert `rst_n`=0 two cycles into CONFIRMA_PRESS → outputs 0 immediately. After reset release with the button still held → one pulse after a fresh 4-sample confirmation.
6. Back-to-back presses: three press/release cycles of 10 cycles each → exactly three pulses, each one cycle wide; `ATIVO_BAIXO`=0 rerun with inverted pad gives an identical pulse train.

Source files
------------

// File: rtl/condicionador_botao_acao_pkg.sv
// Shared definitions for the push-button conditioner: debounce FSM state codes
// and pad-level normalisation.
package condicionador_botao_acao_pkg;

  localparam logic [1:0] SOLTO            = 2'b00;
  localparam logic [1:0] CONFIRMA_PRESS   = 2'b01;
  localparam logic [1:0] PRESSIONADO      = 2'b10;
  localparam logic [1:0] CONFIRMA_SOLTURA = 2'b11;

  // Converts a synchronised pad level to "1 = pressed".
  function automatic logic nivel_pressionado(input logic pad, input logic ativo_baixo);
    return pad ^ ativo_baixo;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Generic 1-bit two-flop synchroniser with asynchronous active-low reset.
// Both flops reset to VALOR_RESET so the output is defined from reset onwards.
module sincronizador_2ff #(
  parameter logic VALOR_RESET = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= VALOR_RESET;
      q    <= VALOR_RESET;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/condicionador_botao_acao.sv
// Push-button conditioner: synchronises and debounces the raw pad and emits one
// single-cycle action_pulso per confirmed press; botao_estavel is the debounced level.
module condicionador_botao_acao
  import condicionador_botao_acao_pkg::*;
#(
  parameter int   CICLOS_DEBOUNCE = 500000,
  parameter logic ATIVO_BAIXO     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic botao_bruto,
  output logic action_pulso,
  output logic botao_estavel
);

  localparam int               CNT_W   = $clog2(CICLOS_DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(CICLOS_DEBOUNCE - 1);

  logic             botao_sinc;
  logic             s;
  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             pulso_nx, estavel_nx;

  // Flops reset to the released pad level, so s reads 0 straight out of reset.
  sincronizador_2ff #(
    .VALOR_RESET(ATIVO_BAIXO)
  ) u_sinc (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (botao_bruto),
    .q    (botao_sinc)
  );

  assign s = nivel_pressionado(botao_sinc, ATIVO_BAIXO);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pulso_nx = 1'b0;
    case (state)
      SOLTO: begin
        if (s) begin
          state_nx = CONFIRMA_PRESS;
          cnt_nx   = CNT_W'(1);
        end
      end
      CONFIRMA_PRESS: begin
        if (!s) begin
          state_nx = SOLTO;
          cnt_nx   = '0;
        end else if (cnt == CNT_FIM) begin
          state_nx = PRESSIONADO;
          cnt_nx   = '0;
          pulso_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      PRESSIONADO: begin
        if (!s) begin
          state_nx = CONFIRMA_SOLTURA;
          cnt_nx   = CNT_W'(1);
        end
      end
      CONFIRMA_SOLTURA: begin
        if (s) begin
          state_nx = PRESSIONADO;
          cnt_nx   = '0;
        end else if (cnt == CNT_FIM) begin
          state_nx = SOLTO;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = SOLTO;
        cnt_nx   = '0;
      end
    endcase
    estavel_nx = (state_nx == PRESSIONADO) || (state_nx == CONFIRMA_SOLTURA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SOLTO;
      cnt           <= '0;
      action_pulso  <= 1'b0;
      botao_estavel <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      action_pulso  <= pulso_nx;
      botao_estavel <= estavel_nx;
    end
  end

endmodule

// File: tb/tb_condicionador_botao_acao.sv
// Bench for condicionador_botao_acao: active-low and active-high instances driven
// with mirrored pads, both checked against a sample-history model of the debouncer.
module tb_condicionador_botao_acao;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pad = 1'b1;            // active-low pad level; the active-high instance sees ~pad
  logic pad_inv;
  logic pulso_ab, estavel_ab, pulso_aa, estavel_aa;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  bit sq[$];                   // pressed levels sampled by the pad flops
  bit sh[$];                   // last N pressed levels seen by the debouncer
  bit stable  = 1'b0;
  bit exp_pul = 1'b0;

  assign pad_inv = ~pad;

  always #5 clk = ~clk;

  condicionador_botao_acao #(.CICLOS_DEBOUNCE(N), .ATIVO_BAIXO(1'b1)) dut_ab (
    .clk(clk), .rst_n(rst_n), .botao_bruto(pad),
    .action_pulso(pulso_ab), .botao_estavel(estavel_ab));

  condicionador_botao_acao #(.CICLOS_DEBOUNCE(N), .ATIVO_BAIXO(1'b0)) dut_aa (
    .clk(clk), .rst_n(rst_n), .botao_bruto(pad_inv),
    .action_pulso(pulso_aa), .botao_estavel(estavel_aa));

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    sq.delete();
    sh.delete();
    stable  = 1'b0;
    exp_pul = 1'b0;
  endtask

  // The level flips once the last N debouncer samples all disagree with it;
  // those samples lag the pad by two clock edges.
  task automatic model_edge();
    bit s;
    bit all_diff;
    exp_pul = 1'b0;
    if (!rst_n) return;
    sq.push_back(~pad);
    if (sq.size() > 3) void'(sq.pop_front());
    s = (sq.size() == 3) ? sq[0] : 1'b0;
    sh.push_back(s);
    if (sh.size() > N) void'(sh.pop_front());
    all_diff = (sh.size() == N);
    foreach (sh[i]) if (sh[i] == stable) all_diff = 1'b0;
    if (all_diff) begin
      stable  = ~stable;
      exp_pul = stable;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_pulso_ab"},   pulso_ab,   exp_pul);
    check_eq({tag, "_estavel_ab"}, estavel_ab, stable);
    check_eq({tag, "_pulso_aa"},   pulso_aa,   exp_pul);
    check_eq({tag, "_estavel_aa"}, estavel_aa, stable);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic async_reset(input string tag, input int hold);
    rst_n = 1'b0;
    model_clear();
    #1;
    check_outputs({tag, "_imm"});
    for (int i = 0; i < hold; i++) step({tag, "_hold"});
    rst_n = 1'b1;
  endtask

  // Holds the pad at v for len edges; returns the edge index (1-based) of the
  // first pulse or first change of botao_estavel, 0 if none.
  task automatic hold_measure(input string tag, input logic v, input int len,
                              output int lat_pulse, output int lat_lvl);
    logic lvl0;
    lvl0 = estavel_ab;
    lat_pulse = 0;
    lat_lvl   = 0;
    pad = v;
    for (int i = 1; i <= len; i++) begin
      step(tag);
      if (pulso_ab && lat_pulse == 0) lat_pulse = i;
      if (estavel_ab != lvl0 && lat_lvl == 0) lat_lvl = i;
    end
  endtask

  initial begin
    int lp, ll, npulse, runlen;
    logic lv;

    // Reset held with the button pressed
    pad = 1'b0;
    model_clear();
    #1;
    check_outputs("rst_init");
    for (int i = 0; i < 5; i++) step("rst_hold");
    rst_n = 1'b1;
    lp = 0;
    for (int i = 1; i <= 10; i++) begin
      step("rst_rel");
      if (pulso_ab && lp == 0) lp = i;
    end
    check_eq("rst_rel_latency", lp, N + 2);

    // Clean release then clean press
    hold_measure("release1", 1'b1, 12, lp, ll);
    check_eq("release1_nopulse", lp, 0);
    check_eq("release1_latency", ll, N + 2);
    hold_measure("press", 1'b0, 20, lp, ll);
    check_eq("press_latency", lp, N + 2);
    check_eq("press_lvl_latency", ll, N + 2);
    hold_measure("release2", 1'b1, 12, lp, ll);
    check_eq("release2_nopulse", lp, 0);
    check_eq("release2_latency", ll, N + 2);

    // Bounce: toggle every 2 cycles, then settle pressed
    npulse = 0;
    for (int i = 0; i < 16; i++) begin
      pad = (i / 2) % 2 == 0 ? 1'b0 : 1'b1;
      step("bounce");
      if (pulso_ab) npulse++;
    end
    check_eq("bounce_nopulse", npulse, 0);
    hold_measure("bounce_settle", 1'b0, 12, lp, ll);
    check_eq("bounce_settle_latency", lp, N + 2);

    // Release glitch while pressed
    hold_measure("glitch", 1'b1, 2, lp, ll);
    hold_measure("glitch_after", 1'b0, 10, lp, ll);
    check_eq("glitch_nopulse", lp, 0);
    check_eq("glitch_level", estavel_ab, 1);

    // Reset two cycles into press confirmation, button kept pressed
    hold_measure("pre_mid", 1'b1, 12, lp, ll);
    hold_measure("mid_conf", 1'b0, 4, lp, ll);
    async_reset("mid_conf_rst", 3);
    hold_measure("mid_conf_rel", 1'b0, 10, lp, ll);
    check_eq("mid_conf_latency", lp, N + 2);

    // Reset while the pulse is high
    hold_measure("pre_pulse", 1'b1, 12, lp, ll);
    hold_measure("to_pulse", 1'b0, N + 2, lp, ll);
    check_eq("pulse_before_rst", pulso_ab, 1);
    async_reset("mid_pulse_rst", 2);
    hold_measure("mid_pulse_rel", 1'b1, 12, lp, ll);

    // Back-to-back presses
    npulse = 0;
    for (int r = 0; r < 3; r++) begin
      pad = 1'b0;
      for (int i = 0; i < 10; i++) begin
        step("b2b");
        if (pulso_ab) npulse++;
        if (pulso_aa) npulse++;
      end
      pad = 1'b1;
      for (int i = 0; i < 10; i++) begin
        step("b2b");
        if (pulso_ab) npulse++;
        if (pulso_aa) npulse++;
      end
    end
    check_eq("b2b_pulse_count", npulse, 6);

    // Random pad activity with occasional resets
    for (int k = 0; k < 400; k++) begin
      lv = 1'($urandom_range(0, 1));
      runlen = $urandom_range(1, 2 * N + 2);
      pad = lv;
      for (int i = 0; i < runlen; i++) step("rand");
      if ($urandom_range(0, 59) == 0) async_reset("rand_rst", $urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
